// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: widths, ALU op-codes, EX control bundle and stage actions.
// Used by the ID/EX stage and reused by the downstream EX/MEM stage.
package cpu_pipe_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALU_OP_W   = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'h0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'h1;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'h2;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'h3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'h4;
  localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'h5;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'h6;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'h7;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'h8;
  localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'h9;
  localparam logic [ALU_OP_W-1:0] ALU_LUI = 4'ha;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
  } id_ex_ctrl_t;

  typedef enum logic [1:0] {
    ActLoad,
    ActBubble,
    ActHold
  } stage_action_e;

  // An invalid slot may carry stale fields, but must never write state.
  function automatic id_ex_ctrl_t qualify_ctrl(input id_ex_ctrl_t ctrl, input logic valid);
    id_ex_ctrl_t q;
    q           = ctrl;
    q.reg_write = ctrl.reg_write & valid;
    q.mem_read  = ctrl.mem_read & valid;
    q.mem_write = ctrl.mem_write & valid;
    return q;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the instruction in ID.
// Register 0 is hardwired, so a load targeting it never creates a dependency.
module load_use_detect #(
  parameter int unsigned REG_ADDR_W = cpu_pipe_pkg::REG_ADDR_W
) (
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_reg_dst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  output logic                  load_use
);

  logic dst_nonzero;
  logic src_match;

  always_comb begin
    dst_nonzero = |ex_reg_dst;
    src_match   = (ex_reg_dst == id_rs) | (ex_reg_dst == id_rt);
    load_use    = ex_valid & ex_mem_read & dst_nonzero & id_valid & src_match;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and memory-stall hold.
// Optional ID_EX_STALL_COUNTER_EN adds saturating load-use and flush bubble counters.
module id_ex_stage #(
  parameter int unsigned DATA_W     = cpu_pipe_pkg::DATA_W,
  parameter int unsigned REG_ADDR_W = cpu_pipe_pkg::REG_ADDR_W,
  parameter int unsigned ALU_OP_W   = cpu_pipe_pkg::ALU_OP_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_reg_dst,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_mem_to_reg,
  input  logic                  id_alu_src,
  input  logic [ALU_OP_W-1:0]   id_alu_op,
  input  logic [DATA_W-1:0]     id_read_data1,
  input  logic [DATA_W-1:0]     id_read_data2,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic                  ex_flush,
  input  logic                  mem_stall,
  output logic                  id_ex_valid,
  output logic [REG_ADDR_W-1:0] id_ex_reg_rs,
  output logic [REG_ADDR_W-1:0] id_ex_reg_rt,
  output logic [REG_ADDR_W-1:0] id_ex_reg_dst,
  output logic                  id_ex_reg_write,
  output logic                  id_ex_mem_read,
  output logic                  id_ex_mem_write,
  output logic                  id_ex_mem_to_reg,
  output logic                  id_ex_alu_src,
  output logic [ALU_OP_W-1:0]   id_ex_alu_op,
  output logic [DATA_W-1:0]     id_ex_data1,
  output logic [DATA_W-1:0]     id_ex_data2,
  output logic [DATA_W-1:0]     id_ex_imm,
  output logic                  stall_upstream
`ifdef ID_EX_STALL_COUNTER_EN
  ,
  output logic [31:0]           stall_count,
  output logic [31:0]           flush_count
`endif
);

  import cpu_pipe_pkg::*;

  logic                  valid_q;
  logic [REG_ADDR_W-1:0] rs_q, rt_q, dst_q;
  id_ex_ctrl_t           ctrl_q;
  logic [ALU_OP_W-1:0]   alu_op_q;
  logic [DATA_W-1:0]     data1_q, data2_q, imm_q;

  id_ex_ctrl_t   id_ctrl;
  logic          load_use;
  stage_action_e action;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detect (
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_reg_dst  (dst_q),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .load_use    (load_use)
  );

  always_comb begin
    id_ctrl            = '0;
    id_ctrl.reg_write  = id_reg_write;
    id_ctrl.mem_read   = id_mem_read;
    id_ctrl.mem_write  = id_mem_write;
    id_ctrl.mem_to_reg = id_mem_to_reg;
    id_ctrl.alu_src    = id_alu_src;
  end

  always_comb begin
    action = ActLoad;
    if (mem_stall) begin
      action = ActHold;
    end else if (ex_flush || load_use) begin
      action = ActBubble;
    end
  end

  // A flushed ID instruction is discarded, so there is nothing to hold upstream.
  assign stall_upstream = mem_stall | (load_use & ~ex_flush);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      rs_q     <= '0;
      rt_q     <= '0;
      dst_q    <= '0;
      ctrl_q   <= '0;
      alu_op_q <= '0;
      data1_q  <= '0;
      data2_q  <= '0;
      imm_q    <= '0;
    end else begin
      unique case (action)
        ActLoad: begin
          valid_q  <= id_valid;
          rs_q     <= id_rs;
          rt_q     <= id_rt;
          dst_q    <= id_reg_dst;
          ctrl_q   <= qualify_ctrl(id_ctrl, id_valid);
          alu_op_q <= id_alu_op;
          data1_q  <= id_read_data1;
          data2_q  <= id_read_data2;
          imm_q    <= id_imm;
        end
        ActBubble: begin
          valid_q  <= 1'b0;
          rs_q     <= '0;
          rt_q     <= '0;
          dst_q    <= '0;
          ctrl_q   <= '0;
          alu_op_q <= '0;
          data1_q  <= '0;
          data2_q  <= '0;
          imm_q    <= '0;
        end
        ActHold: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign id_ex_valid      = valid_q;
  assign id_ex_reg_rs     = rs_q;
  assign id_ex_reg_rt     = rt_q;
  assign id_ex_reg_dst    = dst_q;
  assign id_ex_reg_write  = ctrl_q.reg_write;
  assign id_ex_mem_read   = ctrl_q.mem_read;
  assign id_ex_mem_write  = ctrl_q.mem_write;
  assign id_ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign id_ex_alu_src    = ctrl_q.alu_src;
  assign id_ex_alu_op     = alu_op_q;
  assign id_ex_data1      = data1_q;
  assign id_ex_data2      = data2_q;
  assign id_ex_imm        = imm_q;

`ifdef ID_EX_STALL_COUNTER_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;
  logic        stall_bubble;
  logic        flush_bubble;

  // A flush that coincides with a load-use hazard counts as a flush only.
  assign stall_bubble = (action == ActBubble) & ~ex_flush;
  assign flush_bubble = (action == ActBubble) & ex_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_bubble && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (flush_bubble && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; counter checks compile in with
// ID_EX_STALL_COUNTER_EN.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_reg_dst;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src;
  logic [3:0]  id_alu_op;
  logic [31:0] id_read_data1, id_read_data2, id_imm;
  logic        ex_flush, mem_stall;
  logic        id_ex_valid;
  logic [4:0]  id_ex_reg_rs, id_ex_reg_rt, id_ex_reg_dst;
  logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_alu_src;
  logic [3:0]  id_ex_alu_op;
  logic [31:0] id_ex_data1, id_ex_data2, id_ex_imm;
  logic        stall_upstream;
`ifdef ID_EX_STALL_COUNTER_EN
  logic [31:0] stall_count, flush_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk              (clk),
    .reset            (reset),
    .id_valid         (id_valid),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .id_reg_dst       (id_reg_dst),
    .id_reg_write     (id_reg_write),
    .id_mem_read      (id_mem_read),
    .id_mem_write     (id_mem_write),
    .id_mem_to_reg    (id_mem_to_reg),
    .id_alu_src       (id_alu_src),
    .id_alu_op        (id_alu_op),
    .id_read_data1    (id_read_data1),
    .id_read_data2    (id_read_data2),
    .id_imm           (id_imm),
    .ex_flush         (ex_flush),
    .mem_stall        (mem_stall),
    .id_ex_valid      (id_ex_valid),
    .id_ex_reg_rs     (id_ex_reg_rs),
    .id_ex_reg_rt     (id_ex_reg_rt),
    .id_ex_reg_dst    (id_ex_reg_dst),
    .id_ex_reg_write  (id_ex_reg_write),
    .id_ex_mem_read   (id_ex_mem_read),
    .id_ex_mem_write  (id_ex_mem_write),
    .id_ex_mem_to_reg (id_ex_mem_to_reg),
    .id_ex_alu_src    (id_ex_alu_src),
    .id_ex_alu_op     (id_ex_alu_op),
    .id_ex_data1      (id_ex_data1),
    .id_ex_data2      (id_ex_data2),
    .id_ex_imm        (id_ex_imm),
    .stall_upstream   (stall_upstream)
`ifdef ID_EX_STALL_COUNTER_EN
    ,
    .stall_count      (stall_count),
    .flush_count      (flush_count)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] dst, input logic rw, input logic mr,
                       input logic [31:0] d1);
    id_valid      = v;
    id_rs         = rs;
    id_rt         = rt;
    id_reg_dst    = dst;
    id_reg_write  = rw;
    id_mem_read   = mr;
    id_mem_write  = 1'b0;
    id_mem_to_reg = mr;
    id_alu_src    = mr;
    id_alu_op     = 4'h0;
    id_read_data1 = d1;
    id_read_data2 = 32'h0;
    id_imm        = 32'h4;
  endtask

  task automatic test_reset();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
    ex_flush  = 1'b0;
    mem_stall = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++; if (id_ex_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid: got %b want 0", id_ex_valid); end
    checks++; if (id_ex_reg_write !== 1'b0 || id_ex_mem_read !== 1'b0) begin errors++;
      $display("FAIL reset_ctrl: got rw=%b mr=%b want 0", id_ex_reg_write, id_ex_mem_read); end
    checks++; if (id_ex_data1 !== 32'h0 || id_ex_reg_dst !== 5'd0) begin errors++;
      $display("FAIL reset_data: got d1=%h dst=%0d want 0", id_ex_data1, id_ex_reg_dst); end
    checks++; if (stall_upstream !== 1'b0) begin errors++;
      $display("FAIL reset_stall: got %b want 0", stall_upstream); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_load();
    drive(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 32'h11);
    step();
    checks++; if (id_ex_reg_rs !== 5'd3 || id_ex_reg_rt !== 5'd4 || id_ex_reg_dst !== 5'd5) begin
      errors++; $display("FAIL load_regs: got rs=%0d rt=%0d dst=%0d want 3 4 5",
                         id_ex_reg_rs, id_ex_reg_rt, id_ex_reg_dst); end
    checks++; if (id_ex_data1 !== 32'h11 || id_ex_valid !== 1'b1 || id_ex_reg_write !== 1'b1) begin
      errors++; $display("FAIL load_fields: got d1=%h v=%b rw=%b want 11 1 1",
                         id_ex_data1, id_ex_valid, id_ex_reg_write); end
    checks++; if (stall_upstream !== 1'b0) begin errors++;
      $display("FAIL load_stall: got %b want 0", stall_upstream); end
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd20, 5'd21, 5'd8, 1'b1, 1'b1, 32'h0);
    step();
    drive(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b0, 32'h22);
    #1;
    checks++; if (stall_upstream !== 1'b1) begin errors++;
      $display("FAIL lu_stall: got %b want 1", stall_upstream); end
    step();
    checks++; if (id_ex_valid !== 1'b0 || id_ex_mem_read !== 1'b0 || id_ex_reg_write !== 1'b0) begin
      errors++; $display("FAIL lu_bubble: got v=%b mr=%b rw=%b want 0 0 0",
                         id_ex_valid, id_ex_mem_read, id_ex_reg_write); end
    checks++; if (stall_upstream !== 1'b0) begin errors++;
      $display("FAIL lu_stall_once: got %b want 0", stall_upstream); end
    step();
    checks++; if (id_ex_valid !== 1'b1 || id_ex_reg_rs !== 5'd8 || id_ex_reg_dst !== 5'd10) begin
      errors++; $display("FAIL lu_resume: got v=%b rs=%0d dst=%0d want 1 8 10",
                         id_ex_valid, id_ex_reg_rs, id_ex_reg_dst); end
  endtask

  task automatic test_zero_dst();
    drive(1'b1, 5'd20, 5'd21, 5'd0, 1'b1, 1'b1, 32'h0);
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 32'h33);
    #1;
    checks++; if (stall_upstream !== 1'b0) begin errors++;
      $display("FAIL zero_stall: got %b want 0", stall_upstream); end
    step();
    checks++; if (id_ex_valid !== 1'b1 || id_ex_reg_dst !== 5'd3 || id_ex_data1 !== 32'h33) begin
      errors++; $display("FAIL zero_load: got v=%b dst=%0d d1=%h want 1 3 33",
                         id_ex_valid, id_ex_reg_dst, id_ex_data1); end
  endtask

  task automatic test_flush();
    drive(1'b1, 5'd20, 5'd21, 5'd8, 1'b1, 1'b1, 32'h0);
    step();
    drive(1'b1, 5'd8, 5'd1, 5'd11, 1'b1, 1'b0, 32'h44);
    ex_flush = 1'b1;
    #1;
    checks++; if (stall_upstream !== 1'b0) begin errors++;
      $display("FAIL flush_stall: got %b want 0", stall_upstream); end
    step();
    ex_flush = 1'b0;
    checks++; if (id_ex_valid !== 1'b0 || id_ex_reg_write !== 1'b0 || id_ex_reg_rs !== 5'd0) begin
      errors++; $display("FAIL flush_bubble: got v=%b rw=%b rs=%0d want 0 0 0",
                         id_ex_valid, id_ex_reg_write, id_ex_reg_rs); end
  endtask

  task automatic test_mem_stall();
    drive(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 32'hab);
    step();
    drive(1'b1, 5'd3, 5'd4, 5'd12, 1'b1, 1'b0, 32'hcd);
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stall_upstream !== 1'b1) begin errors++;
        $display("FAIL hold_stall_%0d: got %b want 1", i, stall_upstream); end
      step();
      checks++; if (id_ex_data1 !== 32'hab || id_ex_reg_dst !== 5'd7 || id_ex_valid !== 1'b1) begin
        errors++; $display("FAIL hold_frozen_%0d: got d1=%h dst=%0d v=%b want ab 7 1",
                           i, id_ex_data1, id_ex_reg_dst, id_ex_valid); end
    end
    mem_stall = 1'b0;
    step();
    checks++; if (id_ex_data1 !== 32'hcd || id_ex_reg_dst !== 5'd12) begin errors++;
      $display("FAIL hold_release: got d1=%h dst=%0d want cd 12", id_ex_data1, id_ex_reg_dst); end
  endtask

  task automatic test_invalid_load();
    drive(1'b0, 5'd6, 5'd2, 5'd14, 1'b1, 1'b1, 32'h55);
    id_mem_write = 1'b1;
    step();
    checks++; if (id_ex_valid !== 1'b0 || id_ex_reg_write !== 1'b0 || id_ex_mem_read !== 1'b0 ||
                  id_ex_mem_write !== 1'b0) begin errors++;
      $display("FAIL inv_ctrl: got v=%b rw=%b mr=%b mw=%b want 0 0 0 0", id_ex_valid,
               id_ex_reg_write, id_ex_mem_read, id_ex_mem_write); end
    checks++; if (id_ex_reg_rs !== 5'd6 || id_ex_data1 !== 32'h55 || id_ex_mem_to_reg !== 1'b1) begin
      errors++; $display("FAIL inv_fields: got rs=%0d d1=%h m2r=%b want 6 55 1",
                         id_ex_reg_rs, id_ex_data1, id_ex_mem_to_reg); end
  endtask

  task automatic test_back_to_back();
    // Bubble then memory stall: the bubble is held and upstream stays stalled.
    drive(1'b1, 5'd20, 5'd21, 5'd8, 1'b1, 1'b1, 32'h0);
    step();
    drive(1'b1, 5'd8, 5'd1, 5'd13, 1'b1, 1'b0, 32'h66);
    step();
    mem_stall = 1'b1;
    #1;
    checks++; if (stall_upstream !== 1'b1) begin errors++;
      $display("FAIL lu_hold_stall: got %b want 1", stall_upstream); end
    step();
    checks++; if (id_ex_valid !== 1'b0) begin errors++;
      $display("FAIL lu_hold_bubble: got %b want 0", id_ex_valid); end
    mem_stall = 1'b0;
    step();
    checks++; if (id_ex_valid !== 1'b1 || id_ex_reg_dst !== 5'd13) begin errors++;
      $display("FAIL lu_hold_resume: got v=%b dst=%0d want 1 13", id_ex_valid, id_ex_reg_dst); end
    // Hazard on rt while memory stalls: the load stays in EX, bubble follows release.
    drive(1'b1, 5'd20, 5'd21, 5'd9, 1'b1, 1'b1, 32'h0);
    step();
    drive(1'b1, 5'd2, 5'd9, 5'd15, 1'b1, 1'b0, 32'h77);
    mem_stall = 1'b1;
    step();
    checks++; if (id_ex_mem_read !== 1'b1 || id_ex_reg_dst !== 5'd9) begin errors++;
      $display("FAIL rt_hold: got mr=%b dst=%0d want 1 9", id_ex_mem_read, id_ex_reg_dst); end
    mem_stall = 1'b0;
    #1;
    checks++; if (stall_upstream !== 1'b1) begin errors++;
      $display("FAIL rt_stall: got %b want 1", stall_upstream); end
    step();
    checks++; if (id_ex_valid !== 1'b0) begin errors++;
      $display("FAIL rt_bubble: got %b want 0", id_ex_valid); end
    step();
    checks++; if (id_ex_valid !== 1'b1 || id_ex_reg_rt !== 5'd9 || id_ex_data1 !== 32'h77) begin
      errors++; $display("FAIL rt_resume: got v=%b rt=%0d d1=%h want 1 9 77",
                         id_ex_valid, id_ex_reg_rt, id_ex_data1); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 5'd20, 5'd21, 5'd8, 1'b1, 1'b1, 32'h0);
    step();
    drive(1'b1, 5'd8, 5'd1, 5'd16, 1'b1, 1'b0, 32'h88);
    #2 reset = 1'b1;
    #1;
    checks++; if (id_ex_valid !== 1'b0 || id_ex_mem_read !== 1'b0 || id_ex_reg_dst !== 5'd0) begin
      errors++; $display("FAIL mid_reset_regs: got v=%b mr=%b dst=%0d want 0 0 0",
                         id_ex_valid, id_ex_mem_read, id_ex_reg_dst); end
    checks++; if (stall_upstream !== 1'b0) begin errors++;
      $display("FAIL mid_reset_stall: got %b want 0", stall_upstream); end
    @(negedge clk);
    reset = 1'b0;
    step();
    checks++; if (id_ex_valid !== 1'b1 || id_ex_reg_dst !== 5'd16) begin errors++;
      $display("FAIL mid_reset_after: got v=%b dst=%0d want 1 16", id_ex_valid, id_ex_reg_dst); end
  endtask

`ifdef ID_EX_STALL_COUNTER_EN
  task automatic test_counters();
    #2 reset = 1'b1;
    #1;
    checks++; if (stall_count !== 32'd0 || flush_count !== 32'd0) begin errors++;
      $display("FAIL cnt_reset: got s=%0d f=%0d want 0 0", stall_count, flush_count); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd20, 5'd21, 5'd8, 1'b1, 1'b1, 32'h0);
      step();
      drive(1'b1, 5'd8, 5'd1, 5'd17, 1'b1, 1'b0, 32'h0);
      step();
    end
    // Hazard under a memory stall is a HOLD, not a counted bubble.
    drive(1'b1, 5'd20, 5'd21, 5'd8, 1'b1, 1'b1, 32'h0);
    step();
    drive(1'b1, 5'd8, 5'd1, 5'd17, 1'b1, 1'b0, 32'h0);
    mem_stall = 1'b1;
    step();
    mem_stall = 1'b0;
    ex_flush  = 1'b1;
    step();
    drive(1'b1, 5'd1, 5'd2, 5'd18, 1'b1, 1'b0, 32'h0);
    step();
    ex_flush = 1'b0;
    checks++; if (stall_count !== 32'd4 || flush_count !== 32'd2) begin errors++;
      $display("FAIL cnt_values: got s=%0d f=%0d want 4 2", stall_count, flush_count); end
    step();
    #2 reset = 1'b1;
    #1;
    checks++; if (stall_count !== 32'd0 || flush_count !== 32'd0 || id_ex_valid !== 1'b0) begin
      errors++; $display("FAIL cnt_mid_reset: got s=%0d f=%0d v=%b want 0 0 0",
                         stall_count, flush_count, id_ex_valid); end
    @(negedge clk);
    reset = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_load_use();
    test_zero_dst();
    test_flush();
    test_mem_stall();
    test_invalid_load();
    test_back_to_back();
    test_reset_mid();
`ifdef ID_EX_STALL_COUNTER_EN
    test_counters();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
